// File: rtl/pc_fetch_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_gen
//  Description : Fetch-PC generator. Issues icache requests over a valid/ready
//                handshake, takes prioritised redirects, discards stale
//                responses after a redirect and buffers one response in a skid
//                register while the IF/ID stage is held.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_gen #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                NUM_REDIR  = 2,
    parameter int                INST_BYTES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    stall_i,
    input  logic [NUM_REDIR-1:0]          redir_valid_i,
    input  logic [NUM_REDIR*ADDR_W-1:0]   redir_pc_i,
    output logic                          req_valid_o,
    output logic [ADDR_W-1:0]             req_addr_o,
    input  logic                          req_ready_i,
    input  logic                          resp_valid_i,
    input  logic [31:0]                   resp_inst_i,
    output logic [ADDR_W-1:0]             pc_o,
    output logic [31:0]                   inst_o,
    output logic                          valid_o
);

    // Fetch sequencer states
    localparam logic [1:0] c_ST_REQ  = 2'd0;  // issue a request
    localparam logic [1:0] c_ST_WAIT = 2'd1;  // live response pending
    localparam logic [1:0] c_ST_DROP = 2'd2;  // stale response pending, discard it

    localparam logic [ADDR_W-1:0] c_PC_STEP = ADDR_W'(INST_BYTES);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_skid_valid;
    logic [ADDR_W-1:0] r_skid_pc;
    logic [31:0]       r_skid_inst;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_inst;
    logic              r_valid;

    logic              w_any_redir;
    logic [ADDR_W-1:0] w_redir_pc;
    logic              w_fetched;
    logic              w_pass;
    logic              w_bubble;
    logic              w_req_valid;

    // Pick the lowest-index asserted redirect channel (scan downwards so index 0 wins)
    always_comb begin
        w_redir_pc = '0;
        for (int k = NUM_REDIR - 1; k >= 0; k--) begin
            if (redir_valid_i[k]) begin
                w_redir_pc = redir_pc_i[k*ADDR_W +: ADDR_W];
            end
        end
    end

    assign w_any_redir = |redir_valid_i;
    // 2'b11 falls into hold because it is neither pass nor bubble
    assign w_pass      = (stall_i == 2'b00);
    assign w_bubble    = (stall_i == 2'b10);
    // A live response for the current fetch_pc
    assign w_fetched   = (r_state == c_ST_WAIT) && resp_valid_i;
    // Requests are blocked while the skid is full so a response can never collide with it
    assign w_req_valid = (r_state == c_ST_REQ) && !r_skid_valid && !w_any_redir;

    assign req_valid_o = w_req_valid;
    assign req_addr_o  = r_fetch_pc;
    assign pc_o        = r_pc;
    assign inst_o      = r_inst;
    assign valid_o     = r_valid;

    // Fetch sequencer and fetch PC; a redirect overrides normal sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_REQ;
            r_fetch_pc <= RESET_PC;
        end else if (w_any_redir) begin
            r_fetch_pc <= w_redir_pc;
            // An outstanding response that has not yet returned becomes stale
            if (((r_state == c_ST_WAIT) || (r_state == c_ST_DROP)) && !resp_valid_i) begin
                r_state <= c_ST_DROP;
            end else begin
                r_state <= c_ST_REQ;
            end
        end else begin
            case (r_state)
                c_ST_REQ: begin
                    if (w_req_valid && req_ready_i) begin
                        r_state <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (resp_valid_i) begin
                        r_state    <= c_ST_REQ;
                        r_fetch_pc <= r_fetch_pc + c_PC_STEP;
                    end
                end
                c_ST_DROP: begin
                    if (resp_valid_i) begin
                        r_state <= c_ST_REQ;
                    end
                end
                default: begin
                    r_state <= c_ST_REQ;
                end
            endcase
        end
    end

    // Skid buffer and decode-facing output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid_valid <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_inst  <= '0;
            r_pc         <= '0;
            r_inst       <= '0;
            r_valid      <= 1'b0;
        end else if (w_any_redir) begin
            // Anything buffered belongs to the old path
            r_skid_valid <= 1'b0;
            r_valid      <= 1'b0;
        end else if (w_pass) begin
            if (r_skid_valid) begin
                r_pc         <= r_skid_pc;
                r_inst       <= r_skid_inst;
                r_valid      <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_fetched) begin
                r_pc    <= r_fetch_pc;
                r_inst  <= resp_inst_i;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end else begin
            // Hold or bubble: park a newly fetched instruction in the skid
            if (w_fetched) begin
                r_skid_valid <= 1'b1;
                r_skid_pc    <= r_fetch_pc;
                r_skid_inst  <= resp_inst_i;
            end
            if (w_bubble) begin
                r_pc    <= '0;
                r_inst  <= '0;
                r_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
